// File: rtl/blackjack_ctrl.sv
// Blackjack game sequencer: requests cards from the deck, deals the opening hands,
// runs the player hit/stay phase and the dealer draw-to-17 phase, then reports the outcome.
//
// state   | meaning
// IDLE    | no game, waiting for start
// DEAL_P1 | requesting first player card
// DEAL_D1 | requesting first dealer card
// DEAL_P2 | requesting second player card
// DEAL_D2 | requesting second dealer card
// PLAYER  | waiting for hit/stay (auto-stands on 21)
// P_DRAW  | requesting a player hit card
// DEALER  | dealer decides: stand on >= 17, else draw
// D_DRAW  | requesting a dealer card
// RESULT  | outcome flags and totals held until start
module blackjack_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    input  logic       stay,
    input  logic [4:0] card_in,
    input  logic       card_valid,
    output logic       card_req,
    output logic [4:0] player_total,
    output logic [4:0] dealer_total,
    output logic       busy,
    output logic       win,
    output logic       lose,
    output logic       tie
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEAL_P1,
        S_DEAL_D1,
        S_DEAL_P2,
        S_DEAL_D2,
        S_PLAYER,
        S_P_DRAW,
        S_DEALER,
        S_D_DRAW,
        S_RESULT
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] p_hard_q, p_hard_d;
    logic [4:0] d_hard_q, d_hard_d;
    logic       p_ace_q, p_ace_d;
    logic       d_ace_q, d_ace_d;
    logic       win_q, win_d;
    logic       lose_q, lose_d;
    logic       tie_q, tie_d;

    logic       xfer;
    logic       card_is_ace;
    logic [4:0] p_hard_add, d_hard_add;
    logic       p_ace_add, d_ace_add;
    logic [4:0] p_best, d_best;

    // An ace counts 11 only while that keeps the hand at or below 21.
    function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
        if (ace && (hard <= 5'd11)) begin
            return hard + 5'd10;
        end
        return hard;
    endfunction

    assign card_req = (state_q inside {S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2,
                                       S_P_DRAW, S_D_DRAW});
    assign busy     = !(state_q inside {S_IDLE, S_RESULT});

    assign xfer        = card_req && card_valid && (card_in >= 5'd1) && (card_in <= 5'd10);
    assign card_is_ace = (card_in == 5'd1);
    assign p_hard_add  = p_hard_q + card_in;
    assign d_hard_add  = d_hard_q + card_in;
    assign p_ace_add   = p_ace_q | card_is_ace;
    assign d_ace_add   = d_ace_q | card_is_ace;
    assign p_best      = best_total(p_hard_q, p_ace_q);
    assign d_best      = best_total(d_hard_q, d_ace_q);

    assign player_total = p_best;
    assign dealer_total = d_best;
    assign win          = win_q;
    assign lose         = lose_q;
    assign tie          = tie_q;

    always_comb begin
        state_d  = state_q;
        p_hard_d = p_hard_q;
        p_ace_d  = p_ace_q;
        d_hard_d = d_hard_q;
        d_ace_d  = d_ace_q;
        win_d    = win_q;
        lose_d   = lose_q;
        tie_d    = tie_q;
        case (state_q)
            S_IDLE, S_RESULT: begin
                if (start) begin
                    state_d  = S_DEAL_P1;
                    p_hard_d = 5'd0;
                    p_ace_d  = 1'b0;
                    d_hard_d = 5'd0;
                    d_ace_d  = 1'b0;
                    win_d    = 1'b0;
                    lose_d   = 1'b0;
                    tie_d    = 1'b0;
                end
            end
            S_DEAL_P1, S_DEAL_P2: begin
                if (xfer) begin
                    p_hard_d = p_hard_add;
                    p_ace_d  = p_ace_add;
                    state_d  = (state_q == S_DEAL_P1) ? S_DEAL_D1 : S_DEAL_D2;
                end
            end
            S_DEAL_D1, S_DEAL_D2: begin
                if (xfer) begin
                    d_hard_d = d_hard_add;
                    d_ace_d  = d_ace_add;
                    state_d  = (state_q == S_DEAL_D1) ? S_DEAL_P2 : S_PLAYER;
                end
            end
            S_PLAYER: begin
                // stay takes priority over a simultaneous hit
                if ((p_best == 5'd21) || stay) begin
                    state_d = S_DEALER;
                end else if (hit) begin
                    state_d = S_P_DRAW;
                end
            end
            S_P_DRAW: begin
                if (xfer) begin
                    p_hard_d = p_hard_add;
                    p_ace_d  = p_ace_add;
                    if (best_total(p_hard_add, p_ace_add) > 5'd21) begin
                        state_d = S_RESULT;
                        lose_d  = 1'b1;
                    end else begin
                        state_d = S_PLAYER;
                    end
                end
            end
            S_DEALER: begin
                if (d_best >= 5'd17) begin
                    state_d = S_RESULT;
                    if ((d_best > 5'd21) || (p_best > d_best)) begin
                        win_d = 1'b1;
                    end else if (p_best < d_best) begin
                        lose_d = 1'b1;
                    end else begin
                        tie_d = 1'b1;
                    end
                end else begin
                    state_d = S_D_DRAW;
                end
            end
            S_D_DRAW: begin
                if (xfer) begin
                    d_hard_d = d_hard_add;
                    d_ace_d  = d_ace_add;
                    state_d  = S_DEALER;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            p_hard_q <= 5'd0;
            p_ace_q  <= 1'b0;
            d_hard_q <= 5'd0;
            d_ace_q  <= 1'b0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            tie_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_hard_q <= p_hard_d;
            p_ace_q  <= p_ace_d;
            d_hard_q <= d_hard_d;
            d_ace_q  <= d_ace_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
            tie_q    <= tie_d;
        end
    end

endmodule

// File: tb/tb_blackjack_ctrl.sv
// Bench for blackjack_ctrl: directed games from the test plan plus randomized games
// checked against a card-list model of both hands.
module tb_blackjack_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       hit;
    logic       stay;
    logic [4:0] card_in;
    logic       card_valid;
    logic       card_req;
    logic [4:0] player_total;
    logic [4:0] dealer_total;
    logic       busy;
    logic       win;
    logic       lose;
    logic       tie;

    int checks = 0;
    int errors = 0;
    int p_cards[16];
    int d_cards[16];
    int p_n = 0;
    int d_n = 0;

    blackjack_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .hit          (hit),
        .stay         (stay),
        .card_in      (card_in),
        .card_valid   (card_valid),
        .card_req     (card_req),
        .player_total (player_total),
        .dealer_total (dealer_total),
        .busy         (busy),
        .win          (win),
        .lose         (lose),
        .tie          (tie)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic int hand_best(input int c[16], input int n);
        int  s;
        bit  ace;
        s   = 0;
        ace = 1'b0;
        for (int i = 0; i < n; i++) begin
            s += c[i];
            if (c[i] == 1) ace = 1'b1;
        end
        if (ace && (s + 10 <= 21)) s += 10;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_player(input int v);
        p_cards[p_n] = v;
        p_n++;
    endtask

    task automatic push_dealer(input int v);
        d_cards[d_n] = v;
        d_n++;
    endtask

    // Offer a card while card_req is high; noisy mode first inserts rejected cycles
    // (valid low, value 0, value 11..31) and ignored start/hit/stay pulses.
    task automatic give_card(input int v, input bit noisy);
        int junk;
        check("req_before_card", card_req, 1);
        junk = noisy ? int'($urandom_range(0, 3)) : 0;
        for (int j = 0; j < junk; j++) begin
            case ($urandom_range(0, 2))
                0:       begin card_valid = 1'b0; card_in = 5'($urandom_range(1, 10));  end
                1:       begin card_valid = 1'b1; card_in = 5'd0;                      end
                default: begin card_valid = 1'b1; card_in = 5'($urandom_range(11, 31)); end
            endcase
            start = ($urandom_range(0, 1) == 1);
            hit   = ($urandom_range(0, 1) == 1);
            stay  = ($urandom_range(0, 1) == 1);
            step();
            start = 1'b0;
            hit   = 1'b0;
            stay  = 1'b0;
            check("junk_req_held", card_req, 1);
            check("junk_player_total", player_total, hand_best(p_cards, p_n));
            check("junk_dealer_total", dealer_total, hand_best(d_cards, d_n));
        end
        card_valid = 1'b1;
        card_in    = 5'(v);
        step();
    endtask

    task automatic deal(input int c0, input int c1, input int c2, input int c3, input bit noisy);
        int cs[4];
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        p_n = 0;
        d_n = 0;
        start      = 1'b1;
        card_valid = 1'b1;
        card_in    = 5'(c0);
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_clears_player", player_total, 0);
        check("start_clears_flags", {win, lose, tie}, 0);
        for (int i = 0; i < 4; i++) begin
            give_card(cs[i], noisy);
            if (i % 2 == 0) push_player(cs[i]);
            else            push_dealer(cs[i]);
        end
        check("deal_req_dropped", card_req, 0);
        check("deal_busy", busy, 1);
        check("deal_player_total", player_total, hand_best(p_cards, p_n));
        check("deal_dealer_total", dealer_total, hand_best(d_cards, d_n));
    endtask

    task automatic check_result();
        int pb, db;
        bit ew, el, et;
        pb = hand_best(p_cards, p_n);
        db = hand_best(d_cards, d_n);
        ew = (pb <= 21) && ((db > 21) || (pb > db));
        el = (pb > 21) || ((db <= 21) && (pb < db));
        et = !ew && !el;
        check("res_busy", busy, 0);
        check("res_req", card_req, 0);
        check("res_player_total", player_total, pb);
        check("res_dealer_total", dealer_total, db);
        check("res_win", win, ew);
        check("res_lose", lose, el);
        check("res_tie", tie, et);
        hit  = 1'b1;
        stay = 1'b1;
        step();
        hit  = 1'b0;
        stay = 1'b0;
        step();
        check("hold_busy", busy, 0);
        check("hold_flags", {win, lose, tie}, {29'd0, ew, el, et});
        check("hold_player_total", player_total, pb);
    endtask

    task automatic player_hit(input int v, input bit noisy);
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("hit_req", card_req, 1);
        give_card(v, noisy);
        push_player(v);
        check("hit_player_total", player_total, hand_best(p_cards, p_n));
        if (hand_best(p_cards, p_n) > 21) check_result();
    endtask

    task automatic player_stay(input bit with_hit);
        stay = 1'b1;
        hit  = with_hit;
        step();
        stay = 1'b0;
        hit  = 1'b0;
        check("stay_no_draw", card_req, 0);
        check("stay_player_total", player_total, hand_best(p_cards, p_n));
    endtask

    task automatic run_dealer(input int forced[4], input int nf, input bit noisy, output int draws);
        int budget;
        int v;
        budget = 200;
        draws  = 0;
        while (busy && budget > 0) begin
            if (card_req) begin
                v = (draws < nf) ? forced[draws] : int'($urandom_range(1, 10));
                give_card(v, noisy);
                push_dealer(v);
                draws++;
            end else begin
                step();
            end
            budget--;
        end
        check("dealer_finished", busy, 0);
    endtask

    initial begin
        int forced[4];
        int draws;
        bit bust;

        rst_n      = 1'b0;
        start      = 1'b0;
        hit        = 1'b0;
        stay       = 1'b0;
        card_valid = 1'b0;
        card_in    = 5'd0;
        forced     = '{0, 0, 0, 0};
        #1;
        check("rst_card_req", card_req, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {win, lose, tie}, 0);
        check("rst_player_total", player_total, 0);
        check("rst_dealer_total", dealer_total, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // Game A: 10,9,7,8 -> 17 vs 17, dealer stands, tie
        deal(10, 9, 7, 8, 1'b0);
        check("A_player", player_total, 17);
        check("A_dealer", dealer_total, 17);
        player_stay(1'b0);
        run_dealer(forced, 0, 1'b0, draws);
        check("A_draws", draws, 0);
        check_result();
        check("A_tie", tie, 1);

        // Game B: player soft 18, hits 10 -> hard 18; dealer 16 draws 10 -> 26
        deal(1, 10, 7, 6, 1'b0);
        check("B_player_soft", player_total, 18);
        check("B_dealer", dealer_total, 16);
        player_hit(10, 1'b0);
        check("B_player_hard", player_total, 18);
        player_stay(1'b0);
        forced[0] = 10;
        run_dealer(forced, 1, 1'b0, draws);
        check("B_dealer_bust", dealer_total, 26);
        check_result();
        check("B_win", win, 1);

        // Game C: player 16 hits 9 -> bust, dealer does not draw
        deal(10, 10, 6, 7, 1'b0);
        player_hit(9, 1'b0);
        check("C_player", player_total, 25);
        check("C_lose", lose, 1);
        check("C_dealer", dealer_total, 17);

        // Game D: player blackjack auto-advances; dealer soft 16 draws an ace
        deal(1, 5, 10, 1, 1'b0);
        check("D_player", player_total, 21);
        forced[0] = 1;
        run_dealer(forced, 1, 1'b0, draws);
        check("D_draws", draws, 1);
        check("D_dealer", dealer_total, 17);
        check_result();
        check("D_win", win, 1);

        // Game E: hit and stay together acts as stay
        deal(10, 2, 7, 3, 1'b0);
        player_stay(1'b1);
        run_dealer(forced, 0, 1'b1, draws);
        check_result();

        // Reset while a player card is pending
        deal(2, 3, 4, 5, 1'b0);
        hit        = 1'b1;
        card_valid = 1'b0;
        step();
        hit = 1'b0;
        check("pdraw_req", card_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", card_req, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_player", player_total, 0);
        check("async_rst_dealer", dealer_total, 0);
        check("async_rst_flags", {win, lose, tie}, 0);
        card_valid = 1'b1;
        card_in    = 5'd5;
        @(posedge clk);
        #1;
        check("rst_no_accept", player_total, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", busy, 0);
        check("post_rst_req", card_req, 0);

        // Randomized games with noisy card delivery
        for (int g = 0; g < 40; g++) begin
            deal($urandom_range(1, 10), $urandom_range(1, 10),
                 $urandom_range(1, 10), $urandom_range(1, 10), 1'b1);
            bust = 1'b0;
            while (!bust && (hand_best(p_cards, p_n) < 21) && ($urandom_range(0, 2) != 0)) begin
                player_hit($urandom_range(1, 10), 1'b1);
                if (hand_best(p_cards, p_n) > 21) bust = 1'b1;
            end
            if (!bust) begin
                if (hand_best(p_cards, p_n) < 21) player_stay($urandom_range(0, 1) == 1);
                run_dealer(forced, 0, 1'b1, draws);
                check_result();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
